// File: rtl/readout_sync_pkg.sv
// Shared definitions for the readout-domain line-sync generator.
// The state encoding, minimum low-phase length and default counter width are
// kept here so that the configuration check and the generator agree.
package readout_sync_pkg;

  // Default width of the period, width, delay and line counters.
  localparam int LSG_CNT_W = 16;

  // Minimum number of low cycles between pulses. The downstream 2-flop edge
  // detector needs at least this many low cycles to see every falling phase.
  localparam int LSG_MIN_LOW = 2;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    LSG_IDLE    = 3'd0,
    LSG_DELAY   = 3'd1,
    LSG_SYNC_HI = 3'd2,
    LSG_SYNC_LO = 3'd3,
    LSG_DONE    = 3'd4
  } lsg_state_e;

endpackage : readout_sync_pkg

// File: rtl/lsg_cfg_check.sv
// Combinational validity check for a line-sync frame configuration.
// A frame is legal when it has at least one pulse, every pulse is at least one
// cycle wide, and each line leaves LSG_MIN_LOW low cycles after the pulse.
// The same rule is applied by the software-side register checks.
module lsg_cfg_check
  import readout_sync_pkg::*;
#(
  parameter int CNT_W = LSG_CNT_W
) (
  input  logic [CNT_W-1:0] cfg_line_period_i,
  input  logic [CNT_W-1:0] cfg_sync_width_i,
  input  logic [CNT_W-1:0] cfg_line_count_i,
  output logic             ok
);

  // One extra bit keeps width + LSG_MIN_LOW from wrapping for large widths,
  // so a near-maximum width can never sneak past the period test.
  logic [CNT_W:0] min_period;
  logic           width_ok;
  logic           count_ok;
  logic           period_ok;

  assign min_period = {1'b0, cfg_sync_width_i} + (CNT_W+1)'(LSG_MIN_LOW);
  assign width_ok   = (cfg_sync_width_i != {CNT_W{1'b0}});
  assign count_ok   = (cfg_line_count_i != {CNT_W{1'b0}});
  assign period_ok  = ({1'b0, cfg_line_period_i} >= min_period);
  assign ok         = width_ok & count_ok & period_ok;

endmodule : lsg_cfg_check

// File: rtl/line_sync_gen.sv
// Per-frame line-sync pulse generator for the 20 MHz readout domain.
// On an accepted frame trigger it waits cfg_first_delay cycles, then emits
// cfg_line_count pulses, each cfg_sync_width cycles high, with rising edges
// cfg_line_period cycles apart. The configuration is captured into shadow
// registers at accept, so the frame runs on a stable snapshot.
// gen_sync_start feeds an edge detector directly, so it comes straight from
// a flop and is forced low on abort, disable or reset.
module line_sync_gen
  import readout_sync_pkg::*;
#(
  parameter int CNT_W = LSG_CNT_W
) (
  input  logic             clk_20mhz,
  input  logic             rst_n_20mhz,
  input  logic             enable_i,
  input  logic             frame_start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] cfg_line_period_i,
  input  logic [CNT_W-1:0] cfg_sync_width_i,
  input  logic [CNT_W-1:0] cfg_line_count_i,
  input  logic [CNT_W-1:0] cfg_first_delay_i,
  output logic             gen_sync_start,
  output logic [CNT_W-1:0] line_idx_o,
  output logic             frame_busy_o,
  output logic             frame_done_o,
  output logic             aborted_o,
  output logic             cfg_err_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Sequencer state and phase counter.
  lsg_state_e       state_q;
  logic [CNT_W-1:0] phase_cnt_q;

  // Configuration snapshot taken at accept.
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] delay_q;

  // Registered outputs.
  logic [CNT_W-1:0] line_idx_q;
  logic             sync_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             cfg_err_q;

  // Decoded conditions for the current cycle.
  logic             cfg_ok;
  logic             accept;
  logic             stop_req;
  logic             delay_last;
  logic             hi_last;
  logic             lo_last;
  logic             more_lines;
  logic [CNT_W-1:0] phase_cnt_inc;
  logic [CNT_W-1:0] low_len;

  lsg_cfg_check #(
    .CNT_W (CNT_W)
  ) u_cfg_check (
    .cfg_line_period_i (cfg_line_period_i),
    .cfg_sync_width_i  (cfg_sync_width_i),
    .cfg_line_count_i  (cfg_line_count_i),
    .ok                (cfg_ok)
  );

  // A trigger is only looked at while idle and enabled.
  assign accept   = (state_q == LSG_IDLE) & enable_i & frame_start_i;
  // Abort or disable ends any running frame, including the DONE cycle.
  assign stop_req = (state_q != LSG_IDLE) & (abort_i | ~enable_i);

  // Each phase counts 0..N-1; the shadows are validated so N >= 1 in every
  // phase that is entered and the subtractions below never underflow.
  assign low_len       = period_q - width_q;
  assign delay_last    = (phase_cnt_q == (delay_q - CNT_ONE));
  assign hi_last       = (phase_cnt_q == (width_q - CNT_ONE));
  assign lo_last       = (phase_cnt_q == (low_len - CNT_ONE));
  assign more_lines    = (line_idx_q < (count_q - CNT_ONE));
  assign phase_cnt_inc = phase_cnt_q + CNT_ONE;

  // Frame sequencer: state, phase counter, shadows and all registered outputs.
  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
    if (!rst_n_20mhz) begin
      state_q     <= LSG_IDLE;
      phase_cnt_q <= CNT_ZERO;
      period_q    <= CNT_ZERO;
      width_q     <= CNT_ZERO;
      count_q     <= CNT_ZERO;
      delay_q     <= CNT_ZERO;
      line_idx_q  <= CNT_ZERO;
      sync_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      // Status strobes are single-cycle unless re-asserted below.
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;

      if (stop_req) begin
        // Terminate the frame; line_idx keeps the line that was running.
        state_q     <= LSG_IDLE;
        phase_cnt_q <= CNT_ZERO;
        sync_q      <= 1'b0;
        busy_q      <= 1'b0;
        aborted_q   <= 1'b1;
      end else begin
        case (state_q)
          LSG_IDLE: begin
            if (accept) begin
              if (cfg_ok) begin
                period_q    <= cfg_line_period_i;
                width_q     <= cfg_sync_width_i;
                count_q     <= cfg_line_count_i;
                delay_q     <= cfg_first_delay_i;
                line_idx_q  <= CNT_ZERO;
                phase_cnt_q <= CNT_ZERO;
                busy_q      <= 1'b1;
                if (cfg_first_delay_i != CNT_ZERO) begin
                  state_q <= LSG_DELAY;
                  sync_q  <= 1'b0;
                end else begin
                  state_q <= LSG_SYNC_HI;
                  sync_q  <= 1'b1;
                end
              end else begin
                // Rejected trigger: flag it and leave everything else alone.
                cfg_err_q <= 1'b1;
              end
            end else begin
              phase_cnt_q <= CNT_ZERO;
            end
          end

          LSG_DELAY: begin
            if (delay_last) begin
              state_q     <= LSG_SYNC_HI;
              phase_cnt_q <= CNT_ZERO;
              sync_q      <= 1'b1;
            end else begin
              phase_cnt_q <= phase_cnt_inc;
            end
          end

          LSG_SYNC_HI: begin
            if (hi_last) begin
              state_q     <= LSG_SYNC_LO;
              phase_cnt_q <= CNT_ZERO;
              sync_q      <= 1'b0;
            end else begin
              phase_cnt_q <= phase_cnt_inc;
            end
          end

          LSG_SYNC_LO: begin
            if (lo_last) begin
              phase_cnt_q <= CNT_ZERO;
              if (more_lines) begin
                // Next line: index advances together with the rising edge.
                state_q    <= LSG_SYNC_HI;
                line_idx_q <= line_idx_q + CNT_ONE;
                sync_q     <= 1'b1;
              end else begin
                state_q <= LSG_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              phase_cnt_q <= phase_cnt_inc;
            end
          end

          LSG_DONE: begin
            state_q     <= LSG_IDLE;
            phase_cnt_q <= CNT_ZERO;
          end

          default: begin
            // Unreachable encodings recover to a quiet idle.
            state_q     <= LSG_IDLE;
            phase_cnt_q <= CNT_ZERO;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gen_sync_start = sync_q;
  assign line_idx_o     = line_idx_q;
  assign frame_busy_o   = busy_q;
  assign frame_done_o   = done_q;
  assign aborted_o      = aborted_q;
  assign cfg_err_o      = cfg_err_q;

endmodule : line_sync_gen
